// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared M-extension multiply defines for the execute-stage multiplier
// issue control: opcode codes, datapath width and operand helpers.
package mdu_issue_ctrl_pkg;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] ZERO_WORD = 64'h0000_0000_0000_0000;

  localparam logic [8:0] INST_MUL   = 9'h001;
  localparam logic [8:0] INST_MULH  = 9'h002;
  localparam logic [8:0] INST_MULHU = 9'h003;
  localparam logic [8:0] INST_MULW  = 9'h004;

  function automatic logic is_legal_op(input logic [8:0] op);
    logic legal;
    case (op)
      INST_MUL, INST_MULH, INST_MULHU, INST_MULW: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Word ops sign-extend the low 32 bits into the full datapath.
  function automatic logic [XLEN-1:0] form_operand(input logic [8:0] op,
                                                   input logic [XLEN-1:0] rs);
    logic [XLEN-1:0] res;
    if (op == INST_MULW) begin
      res = {{(XLEN-32){rs[31]}}, rs[31:0]};
    end else begin
      res = rs;
    end
    return res;
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// Execute-stage issue control for the iterative multiplier: accepts one op,
// holds the multiplier request and operands, and hands the result to writeback.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 72
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [8:0]      ex_opcode,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [4:0]      ex_rd_addr,
  input  logic            flush,
  output logic            mult_ready,
  output logic [8:0]      mul_opcode,
  output logic [XLEN-1:0] mul_op1,
  output logic [XLEN-1:0] mul_op2,
  input  logic            mult_finish,
  input  logic [XLEN-1:0] product_val,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd_addr,
  output logic            wb_err,
  output logic            mdu_stall
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [6:0] WDOG_LAST = 7'(TIMEOUT - 1);

  logic [1:0] state;
  logic [6:0] wdog;

  // Single FSM with all handshake and datapath outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wdog       <= 7'd0;
      ex_ready   <= 1'b1;
      mult_ready <= 1'b0;
      mul_opcode <= 9'd0;
      mul_op1    <= ZERO_WORD;
      mul_op2    <= ZERO_WORD;
      wb_valid   <= 1'b0;
      wb_data    <= ZERO_WORD;
      wb_rd_addr <= 5'd0;
      wb_err     <= 1'b0;
      mdu_stall  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_valid && !flush) begin
            ex_ready   <= 1'b0;
            mdu_stall  <= 1'b1;
            wdog       <= 7'd0;
            wb_rd_addr <= ex_rd_addr;
            if (is_legal_op(ex_opcode)) begin
              mul_opcode <= ex_opcode;
              mul_op1    <= form_operand(ex_opcode, ex_rs1_data);
              mul_op2    <= form_operand(ex_opcode, ex_rs2_data);
              mult_ready <= 1'b1;
              wb_err     <= 1'b0;
              state      <= S_BUSY;
            end else begin
              // Illegal op reports an error without ever starting the multiplier.
              wb_valid   <= 1'b1;
              wb_err     <= 1'b1;
              wb_data    <= ZERO_WORD;
              state      <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            mult_ready <= 1'b0;
            wdog       <= 7'd0;
            state      <= S_DRAIN;
          end else if (mult_finish) begin
            mult_ready <= 1'b0;
            wb_data    <= product_val;
            wb_valid   <= 1'b1;
            wdog       <= 7'd0;
            state      <= S_DONE;
          end else if (wdog == WDOG_LAST) begin
            mult_ready <= 1'b0;
            wb_data    <= ZERO_WORD;
            wb_err     <= 1'b1;
            wb_valid   <= 1'b1;
            wdog       <= 7'd0;
            state      <= S_DONE;
          end else begin
            wdog <= wdog + 7'd1;
          end
        end
        S_DONE: begin
          if (flush || wb_ready) begin
            wb_valid  <= 1'b0;
            wb_err    <= 1'b0;
            ex_ready  <= 1'b1;
            mdu_stall <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // One idle request cycle lets the multiplier drop its internal valid.
          ex_ready  <= 1'b1;
          mdu_stall <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          mult_ready <= 1'b0;
          wb_valid   <= 1'b0;
          ex_ready   <= 1'b1;
          mdu_stall  <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a behavioural iterative multiplier
// (latency = significant bits of |op2|) that can be switched into a never-finishing stub.
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [8:0]  ex_opcode;
  logic [63:0] ex_rs1_data;
  logic [63:0] ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        flush;
  logic        mult_ready;
  logic [8:0]  mul_opcode;
  logic [63:0] mul_op1;
  logic [63:0] mul_op2;
  logic        mult_finish = 1'b0;
  logic [63:0] product_val;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_err;
  logic        mdu_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.TIMEOUT(72)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd_addr(ex_rd_addr), .flush(flush), .mult_ready(mult_ready),
    .mul_opcode(mul_opcode), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mult_finish(mult_finish), .product_val(product_val), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
    .wb_err(wb_err), .mdu_stall(mdu_stall)
  );

  // Behavioural iterative multiplier
  logic        stub_mode = 1'b0;
  logic        m_active  = 1'b0;
  int          m_cnt     = 0;
  logic [63:0] m_prod    = 64'd0;

  function automatic int sigbits(input logic [63:0] v);
    logic [63:0] a;
    int n;
    a = v[63] ? (~v + 64'd1) : v;
    n = 0;
    for (int i = 0; i < 64; i++) if (a[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [63:0] ref_mul(input logic [8:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  r;
    case (op)
      INST_MULH: begin
        p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        r = p[127:64];
      end
      INST_MULHU: begin
        p = {64'd0, a} * {64'd0, b};
        r = p[127:64];
      end
      INST_MULW: begin
        p = {64'd0, a} * {64'd0, b};
        r = {{32{p[31]}}, p[31:0]};
      end
      default: r = a * b;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (!mult_ready) begin
      m_active    <= 1'b0;
      mult_finish <= 1'b0;
    end else if (!m_active) begin
      m_active    <= 1'b1;
      m_cnt       <= sigbits(mul_op2);
      m_prod      <= ref_mul(mul_opcode, mul_op1, mul_op2);
      mult_finish <= !stub_mode && (sigbits(mul_op2) == 0);
    end else begin
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
      mult_finish <= !stub_mode && (m_cnt == 1);
    end
  end

  assign product_val = mult_finish ? m_prod : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op; returns just after the accept edge E0.
  task automatic issue(input logic [8:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    ex_opcode   = op;
    ex_rs1_data = a;
    ex_rs2_data = b;
    ex_rd_addr  = rd;
    ex_valid    = 1'b1;
    step();
    ex_valid    = 1'b0;
  endtask

  // Bounded wait for wb_valid; edges is the index k of the edge E(k) after which it rose.
  task automatic wait_valid(input int max, output int edges);
    edges = 0;
    while (!wb_valid && edges < max) begin
      step();
      edges++;
    end
  endtask

  int lat;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_opcode = 9'd0; ex_rs1_data = 64'd0;
    ex_rs2_data = 64'd0; ex_rd_addr = 5'd0; flush = 1'b0; wb_ready = 1'b1;
    step(); step();
    check_val("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
    check_val("rst_mult_ready", {63'd0, mult_ready}, 64'd0);
    check_val("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check_val("rst_stall", {63'd0, mdu_stall}, 64'd0);
    check_val("rst_wb_data", wb_data, 64'd0);
    rst = 1'b0;
    step();

    // flush in IDLE blocks the accept
    ex_opcode = INST_MUL; ex_rs1_data = 64'd1; ex_rs2_data = 64'd1;
    ex_valid = 1'b1; flush = 1'b1;
    step();
    ex_valid = 1'b0; flush = 1'b0;
    check_val("idle_flush_ready", {63'd0, ex_ready}, 64'd1);
    check_val("idle_flush_mreq", {63'd0, mult_ready}, 64'd0);

    // MUL 7*3
    issue(INST_MUL, 64'd7, 64'd3, 5'd10);
    check_val("mul_mreq_e0", {63'd0, mult_ready}, 64'd1);
    check_val("mul_stall_e0", {63'd0, mdu_stall}, 64'd1);
    check_val("mul_ready_e0", {63'd0, ex_ready}, 64'd0);
    wait_valid(100, lat);
    check_val("mul_latency", 64'(lat), 64'd4);
    check_val("mul_data", wb_data, 64'd21);
    check_val("mul_err", {63'd0, wb_err}, 64'd0);
    check_val("mul_rd", {59'd0, wb_rd_addr}, 64'd10);
    check_val("mul_stall_e4", {63'd0, mdu_stall}, 64'd1);
    check_val("mul_mreq_done", {63'd0, mult_ready}, 64'd0);
    step();
    check_val("mul_hs_valid", {63'd0, wb_valid}, 64'd0);
    check_val("mul_hs_ready", {63'd0, ex_ready}, 64'd1);

    // MULW with sign-extended low word
    issue(INST_MULW, 64'h0000_0001_FFFF_FFFE, 64'd3, 5'd3);
    check_val("mulw_op1", mul_op1, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_valid(100, lat);
    check_val("mulw_latency", 64'(lat), 64'd4);
    check_val("mulw_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFA);
    step();

    // op2=0, writeback back-pressure
    wb_ready = 1'b0;
    issue(INST_MUL, 64'd5, 64'd0, 5'd7);
    wait_valid(100, lat);
    check_val("zero_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("hold_valid", {63'd0, wb_valid}, 64'd1);
      check_val("hold_data", wb_data, 64'd0);
      check_val("hold_ex_ready", {63'd0, ex_ready}, 64'd0);
    end
    wb_ready = 1'b1;
    step();
    check_val("hold_release", {63'd0, wb_valid}, 64'd0);

    // flush in BUSY goes through DRAIN
    issue(INST_MUL, 64'd1, 64'h8000_0000_0000_0001, 5'd2);
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("drain_mreq", {63'd0, mult_ready}, 64'd0);
    check_val("drain_ex_ready", {63'd0, ex_ready}, 64'd0);
    check_val("drain_valid", {63'd0, wb_valid}, 64'd0);
    step();
    check_val("post_drain_ready", {63'd0, ex_ready}, 64'd1);
    check_val("post_drain_valid", {63'd0, wb_valid}, 64'd0);
    issue(INST_MUL, 64'd6, 64'd7, 5'd4);
    wait_valid(100, lat);
    check_val("after_flush_data", wb_data, 64'd42);
    step();

    // watchdog timeout with a stalled multiplier
    stub_mode = 1'b1;
    issue(INST_MUL, 64'd2, 64'd3, 5'd5);
    wait_valid(200, lat);
    check_val("tmo_latency", 64'(lat), 64'd72);
    check_val("tmo_err", {63'd0, wb_err}, 64'd1);
    check_val("tmo_data", wb_data, 64'd0);
    check_val("tmo_mreq", {63'd0, mult_ready}, 64'd0);
    step();
    stub_mode = 1'b0;
    step();

    // illegal opcode
    issue(9'h1FF, 64'd9, 64'd9, 5'd6);
    check_val("ill_valid", {63'd0, wb_valid}, 64'd1);
    check_val("ill_err", {63'd0, wb_err}, 64'd1);
    check_val("ill_data", wb_data, 64'd0);
    check_val("ill_mreq", {63'd0, mult_ready}, 64'd0);
    step();

    // reset mid-BUSY
    issue(INST_MUL, 64'd3, 64'h00FF_FFFF_FFFF_FFFF, 5'd9);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mrst_mreq", {63'd0, mult_ready}, 64'd0);
    check_val("mrst_ex_ready", {63'd0, ex_ready}, 64'd1);
    check_val("mrst_stall", {63'd0, mdu_stall}, 64'd0);
    check_val("mrst_op1", mul_op1, 64'd0);
    check_val("mrst_op2", mul_op2, 64'd0);
    check_val("mrst_opcode", {55'd0, mul_opcode}, 64'd0);
    check_val("mrst_rd", {59'd0, wb_rd_addr}, 64'd0);
    check_val("mrst_valid", {63'd0, wb_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Execute-stage control block that sits directly upstream of the iterative multiplier.
- Accepts one M-extension multiply op from decode/issue with a valid/ready handshake.
- Holds mult_ready and the operands stable for the whole iteration, captures the product on mult_finish, and presents it to writeback with a valid/ready handshake.
- Provides a pipeline stall, a flush abort path and a watchdog.

Parameters:
- TIMEOUT, 72, number of BUSY cycles after which the op is aborted with err.
- XLEN, 64, datapath width. Only 64 is supported.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- ex_valid  input  1  op offered by issue
- ex_ready  output  1  block can accept an op
- ex_opcode  input  9  opcode code from the shared defines
- ex_rs1_data  input  64  source operand 1
- ex_rs2_data  input  64  source operand 2
- ex_rd_addr  input  5  destination register
- flush  input  1  pipeline flush; aborts any op in flight
- mult_ready  output  1  start/hold request to the multiplier
- mul_opcode  output  9  opcode to the multiplier (registered copy)
- mul_op1  output  64  operand 1 to the multiplier (registered)
- mul_op2  output  64  operand 2 to the multiplier (registered)
- mult_finish  input  1  multiplier done strobe (one cycle)
- product_val  input  64  multiplier result; valid only while mult_finish=1
- wb_valid  output  1  result available
- wb_ready  input  1  writeback accepts the result
- wb_data  output  64  result
- wb_rd_addr  output  5  destination register
- wb_err  output  1  result is an error (timeout or illegal opcode); wb_data=0
- mdu_stall  output  1  stall the upstream pipeline

Behaviour:
- All state changes on posedge clk. rst is synchronous active-high and wins over every other input.
- Reset values:
  - state=IDLE.
  - mult_ready, wb_valid, wb_err and mdu_stall are 0.
  - wb_data, mul_op1, mul_op2 and wb_rd_addr are 0.
  - mul_opcode=0 and the watchdog counter=0.
- States:
  - IDLE: ex_ready=1. ex_valid & ~flush captures the op.
    - Legal opcode (INST_MUL, INST_MULH, INST_MULHU, INST_MULW): go to BUSY with mult_ready<=1.
    - Any other opcode: go to DONE with wb_err=1 and wb_data=0; the multiplier is never started.
  - BUSY: mult_ready=1. Operands and opcode are held unchanged. The counter increments each cycle.
    - mult_finish=1: capture product_val into wb_data, set mult_ready<=0, go to DONE.
    - Counter reaches TIMEOUT-1: mult_ready<=0, wb_err<=1, wb_data<=0, go to DONE.
  - DONE: wb_valid=1. wb_data, wb_rd_addr and wb_err are held until wb_valid&wb_ready, then go to IDLE. mult_ready is 0 throughout, which guarantees the multiplier sees at least one idle cycle between ops.
  - DRAIN: entered from BUSY on flush. mult_ready=0 for exactly one cycle, then go to IDLE. This clears the multiplier's internal valid.
- Operand formation at capture:
  - INST_MULW: mul_op1={{32{rs1[31]}},rs1[31:0]} and likewise mul_op2 from rs2.
  - All other opcodes: operands are passed unchanged.
- mdu_stall = ex_valid & ~ex_ready in IDLE is never set. mdu_stall is 1 in BUSY, DONE and DRAIN.
- Latency, counted from the accept edge E0: the multiplier loads at E1, and wb_valid rises after edge E(k+2), where k is the number of significant bits of |mul_op2|.
  - op2=0 gives wb_valid after E2.
  - The maximum is k=64, i.e. wb_valid after E66, which is below TIMEOUT.
- Boundary conditions:
  - flush in IDLE: no accept, even if ex_valid=1.
  - flush in BUSY: go to DRAIN, discard the op, no wb_valid. A simultaneous mult_finish is ignored (flush wins).
  - flush in DONE: drop wb_valid and go to IDLE (the result is discarded). The multiplier is already idle.
  - mult_finish outside BUSY is ignored.
  - wb_ready is ignored unless wb_valid=1.
  - rst mid-BUSY: mult_ready=0 next cycle and state=IDLE. The multiplier self-clears in that cycle.
  - There is no back-to-back accept in the same cycle as the DONE handshake. The next accept happens at the earliest in the following IDLE cycle.

Decomposition:
- Opcode codes (INST_MUL, INST_MULH, INST_MULHU, INST_MULW), XLEN and the zero word stay in the shared defines file.
- The state encoding (IDLE/BUSY/DONE/DRAIN, 2 bits) goes local as localparams.
- No sub-module. The watchdog is a 7-bit counter inline.
- Bench instantiates mdu_issue_ctrl together with the multiplier, plus a stub multiplier for the timeout test.

Test Plan:
- MUL, rs1=7, rs2=3, wb_ready=1 -> wb_valid after E4, wb_data=21, wb_err=0, mdu_stall high E0..E4.
- MULW, rs1=64'h0000_0001_FFFF_FFFE (low word -2), rs2=3 -> wb_data=64'hFFFF_FFFF_FFFF_FFFA.
- MUL, rs1=5, rs2=0 -> wb_valid after E2, wb_data=0. Hold wb_ready=0 for 5 cycles -> wb_valid/wb_data stable, ex_ready=0.
- MUL, rs2=64'h8000_0000_0000_0001, flush at E10 -> DRAIN then IDLE at E12, no wb_valid, mult_ready low at least 1 cycle. Next MUL 6*7 -> 42.
- Stub multiplier never finishes -> wb_err=1, wb_data=0 after TIMEOUT BUSY cycles, mult_ready=0.
- Illegal opcode 9'h1FF -> DONE next cycle, wb_err=1, mult_ready never asserted. rst asserted mid-BUSY -> all outputs at reset values the next cycle.
